// File: rtl/debug_regfile_dump_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// debug_regfile_dump_sequencer_pkg
// Shared definitions for the debug register-file dump path: FSM state
// encodings, request-select field layout, default idle select value and the
// frame-to-byte ratio helper.
// -----------------------------------------------------------------------------
package debug_regfile_dump_sequencer_pkg;

    // Request select layout: {match bit, register address}
    localparam int NB_SELECT     = 6;
    localparam int SEL_MATCH_BIT = 5;
    localparam int SEL_ADDR_MSB  = 4;
    localparam int NB_REG_ADDR   = SEL_ADDR_MSB + 1;

    // Match bit set: the regfile controller does not recognise the request
    localparam logic [NB_SELECT-1:0] DEFAULT_IDLE_SELECT = 6'b100000;

    localparam int DEFAULT_NB_CONTROL_FRAME = 32;
    localparam int DEFAULT_NB_BYTE          = 8;
    localparam int BYTES_PER_FRAME          = DEFAULT_NB_CONTROL_FRAME / DEFAULT_NB_BYTE;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQUEST = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_SEND    = 3'd3,
        ST_DONE    = 3'd4
    } dump_state_e;

    function automatic int bytes_per_frame(input int nb_frame, input int nb_byte);
        return nb_frame / nb_byte;
    endfunction

    function automatic logic [NB_SELECT-1:0] make_select(input logic [NB_REG_ADDR-1:0] addr);
        return {1'b0, addr};
    endfunction

endpackage

// File: rtl/debug_regfile_dump_sequencer_if.sv
// -----------------------------------------------------------------------------
// debug_regfile_dump_sequencer_if
// Bundles the controller-side request/response signals and the TX byte
// valid/ready handshake.
//   master : the dump sequencer (drives select and TX byte stream)
//   slave  : the controller + TX side (returns frame/writing, drives ready)
// Signals:
//   o_request_select        {match bit, reg addr} to the controller
//   i_frame_from_controller frame for the currently selected address
//   i_writing               controller acknowledge (registered match)
//   o_tx_data / o_tx_valid  byte to TX and its valid
//   i_tx_ready              TX can accept a byte
// -----------------------------------------------------------------------------
interface debug_regfile_dump_sequencer_if
    import debug_regfile_dump_sequencer_pkg::*;
#(
    parameter int NB_CONTROL_FRAME = DEFAULT_NB_CONTROL_FRAME,
    parameter int NB_BYTE          = DEFAULT_NB_BYTE
);
    logic [NB_SELECT-1:0]        o_request_select;
    logic [NB_CONTROL_FRAME-1:0] i_frame_from_controller;
    logic                        i_writing;
    logic [NB_BYTE-1:0]          o_tx_data;
    logic                        o_tx_valid;
    logic                        i_tx_ready;

    modport master (
        output o_request_select,
        output o_tx_data,
        output o_tx_valid,
        input  i_frame_from_controller,
        input  i_writing,
        input  i_tx_ready
    );

    modport slave (
        input  o_request_select,
        input  o_tx_data,
        input  o_tx_valid,
        output i_frame_from_controller,
        output i_writing,
        output i_tx_ready
    );
endinterface

// File: rtl/debug_frame_byte_serializer.sv
// -----------------------------------------------------------------------------
// debug_frame_byte_serializer
// Loads a parallel frame and streams it MSB byte first over a valid/ready
// handshake. Pulses o_last in the cycle the final byte is accepted.
// Ports:
//   i_clock, i_reset  clock, synchronous active-high reset
//   i_load, i_frame   parallel load (starts a new frame, raises valid)
//   i_tx_ready        downstream ready
//   o_tx_data         registered byte currently presented
//   o_tx_valid        registered byte valid
//   o_last            combinational: last byte transferred on this edge
// -----------------------------------------------------------------------------
module debug_frame_byte_serializer
    import debug_regfile_dump_sequencer_pkg::*;
#(
    parameter int NB_CONTROL_FRAME = DEFAULT_NB_CONTROL_FRAME,
    parameter int NB_BYTE          = DEFAULT_NB_BYTE
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_load,
    input  logic [NB_CONTROL_FRAME-1:0] i_frame,
    input  logic                        i_tx_ready,
    output logic [NB_BYTE-1:0]          o_tx_data,
    output logic                        o_tx_valid,
    output logic                        o_last
);
    localparam int N_BYTES = bytes_per_frame(NB_CONTROL_FRAME, NB_BYTE);
    localparam int NB_CNT  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam logic [NB_CNT-1:0] LAST_CNT = NB_CNT'(N_BYTES - 1);

    logic [NB_CONTROL_FRAME-1:0] shift_q, shift_d;
    logic [NB_CNT-1:0]           cnt_q, cnt_d;
    logic                        valid_q, valid_d;
    logic                        xfer;
    logic                        last_byte;

    assign xfer      = valid_q & i_tx_ready;
    assign last_byte = (cnt_q == LAST_CNT);

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        if (i_load) begin
            shift_d = i_frame;
            cnt_d   = '0;
            valid_d = 1'b1;
        end else if (xfer) begin
            if (last_byte) begin
                valid_d = 1'b0;
            end else begin
                // Next byte moves into the MSB slot, so back-to-back
                // transfers need no extra cycle.
                shift_d = shift_q << NB_BYTE;
                cnt_d   = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign o_tx_data  = shift_q[NB_CONTROL_FRAME-1 -: NB_BYTE];
    assign o_tx_valid = valid_q;
    assign o_last     = xfer & last_byte;

endmodule

// File: rtl/debug_regfile_dump_sequencer.sv
// -----------------------------------------------------------------------------
// debug_regfile_dump_sequencer
// On i_start walks register addresses 0..N_REGS-1, requests each from the
// regfile controller, captures the returned frame once i_writing acknowledges
// and streams it MSB byte first to the UART TX.
// Ports:
//   i_clock, i_reset  clock, synchronous active-high reset
//   i_start           single-cycle dump request (ignored unless idle)
//   bus               controller request/response and TX byte handshake
//   o_busy            high in every state except IDLE
//   o_done            one-cycle pulse at the end of a dump
//   o_error           sticky acknowledge-timeout flag
// -----------------------------------------------------------------------------
module debug_regfile_dump_sequencer
    import debug_regfile_dump_sequencer_pkg::*;
#(
    parameter int                   NB_CONTROL_FRAME = DEFAULT_NB_CONTROL_FRAME,
    parameter int                   NB_BYTE          = DEFAULT_NB_BYTE,
    parameter int                   N_REGS           = 32,
    parameter int                   NB_TIMEOUT       = 4,
    parameter logic [NB_SELECT-1:0] IDLE_SELECT      = DEFAULT_IDLE_SELECT
) (
    input  logic                           i_clock,
    input  logic                           i_reset,
    input  logic                           i_start,
    debug_regfile_dump_sequencer_if.master bus,
    output logic                           o_busy,
    output logic                           o_done,
    output logic                           o_error
);
    localparam logic [NB_REG_ADDR-1:0] LAST_ADDR = NB_REG_ADDR'(N_REGS - 1);

    dump_state_e             state_q, state_d;
    logic [NB_REG_ADDR-1:0]  addr_q, addr_d;
    logic [NB_SELECT-1:0]    sel_q, sel_d;
    logic [NB_TIMEOUT-1:0]   tmo_q, tmo_d;
    logic [NB_TIMEOUT-1:0]   tmo_inc;
    logic                    tmo_expired;
    logic                    error_q, error_d;
    logic                    done_q, done_d;
    logic                    busy_q, busy_d;
    logic                    load;
    logic                    ser_last;
    logic                    addr_last;
    logic [NB_BYTE-1:0]      ser_data;
    logic                    ser_valid;

    assign tmo_inc     = tmo_q + 1'b1;
    assign tmo_expired = &tmo_inc;
    assign addr_last   = (addr_q == LAST_ADDR);

    debug_frame_byte_serializer #(
        .NB_CONTROL_FRAME (NB_CONTROL_FRAME),
        .NB_BYTE          (NB_BYTE)
    ) u_serializer (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_load     (load),
        .i_frame    (bus.i_frame_from_controller),
        .i_tx_ready (bus.i_tx_ready),
        .o_tx_data  (ser_data),
        .o_tx_valid (ser_valid),
        .o_last     (ser_last)
    );

    // State register plus the registered outputs derived from next state
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            sel_q   <= IDLE_SELECT;
            tmo_q   <= '0;
            error_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            tmo_q   <= tmo_d;
            error_q <= error_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (i_start) state_d = ST_REQUEST;
            // One settle cycle so the controller's registered flag and data
            // belong to the newly selected address.
            ST_REQUEST: state_d = ST_CAPTURE;
            ST_CAPTURE: begin
                if (bus.i_writing)    state_d = ST_SEND;
                else if (tmo_expired) state_d = ST_DONE;
            end
            ST_SEND: begin
                if (ser_last) state_d = addr_last ? ST_DONE : ST_REQUEST;
            end
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        addr_d  = addr_q;
        sel_d   = sel_q;
        tmo_d   = tmo_q;
        error_d = error_q;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                sel_d = IDLE_SELECT;
                if (i_start) begin
                    addr_d  = '0;
                    error_d = 1'b0;
                    sel_d   = make_select('0);
                end
            end
            ST_REQUEST: tmo_d = '0;
            ST_CAPTURE: begin
                if (bus.i_writing) begin
                    load = 1'b1;
                end else begin
                    tmo_d = tmo_inc;
                    if (tmo_expired) begin
                        error_d = 1'b1;
                        sel_d   = IDLE_SELECT;
                    end
                end
            end
            ST_SEND: begin
                if (ser_last) begin
                    if (addr_last) begin
                        sel_d = IDLE_SELECT;
                    end else begin
                        addr_d = addr_q + 1'b1;
                        sel_d  = make_select(addr_q + 1'b1);
                    end
                end
            end
            ST_DONE:  sel_d = IDLE_SELECT;
            default:  sel_d = IDLE_SELECT;
        endcase
    end

    assign done_d = (state_d == ST_DONE);
    assign busy_d = (state_d != ST_IDLE);

    assign bus.o_request_select = sel_q;
    assign bus.o_tx_data        = ser_data;
    assign bus.o_tx_valid       = ser_valid;
    assign o_busy               = busy_q;
    assign o_done               = done_q;
    assign o_error              = error_q;

endmodule

// File: tb/tb_debug_regfile_dump_sequencer.sv
// -----------------------------------------------------------------------------
// tb_debug_regfile_dump_sequencer
// Directed bench: behavioural regfile controller (registered match/frame),
// TX sink with selectable ready pattern, byte capture queue.
// -----------------------------------------------------------------------------
module tb_debug_regfile_dump_sequencer;

    logic clk;
    logic rst;
    logic start;
    logic busy, done, error;

    int n_checks = 0;
    int n_errors = 0;

    // 0: frame 0x100+addr, 1: 0xDEADBEEF, 2: never acknowledge
    int ctrl_mode = 0;
    // 0: ready always high, 1: ready one cycle in three
    int rdy_mode  = 0;

    logic [7:0] q[$];
    int         cyc        = 0;
    int         stall_err  = 0;
    logic       ready_r    = 1'b1;
    logic       last_valid = 1'b0;
    logic       last_ready = 1'b0;
    logic       last_reset = 1'b1;
    logic [7:0] last_data  = 8'h00;

    debug_regfile_dump_sequencer_if #(.NB_CONTROL_FRAME(32), .NB_BYTE(8)) bus ();

    debug_regfile_dump_sequencer #(
        .NB_CONTROL_FRAME (32),
        .NB_BYTE          (8),
        .N_REGS           (32),
        .NB_TIMEOUT       (4),
        .IDLE_SELECT      (6'b100000)
    ) dut (
        .i_clock (clk),
        .i_reset (rst),
        .i_start (start),
        .bus     (bus),
        .o_busy  (busy),
        .o_done  (done),
        .o_error (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Regfile controller: registered match flag and frame
    always @(posedge clk) begin
        if (rst) begin
            bus.i_writing               <= 1'b0;
            bus.i_frame_from_controller <= 32'h0;
        end else begin
            bus.i_writing <= (bus.o_request_select[5] == 1'b0) && (ctrl_mode != 2);
            bus.i_frame_from_controller <= (ctrl_mode == 1) ? 32'hDEADBEEF
                                         : 32'h100 + {27'd0, bus.o_request_select[4:0]};
        end
    end

    // TX sink: sets ready for the next edge and records bytes that will transfer
    always @(negedge clk) begin
        cyc++;
        if (last_valid && !last_ready && !last_reset) begin
            if (bus.o_tx_valid !== 1'b1 || bus.o_tx_data !== last_data) stall_err++;
        end
        ready_r = (rdy_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
        bus.i_tx_ready = ready_r;
        if (bus.o_tx_valid === 1'b1 && ready_r && !rst) q.push_back(bus.o_tx_data);
        last_valid = (bus.o_tx_valid === 1'b1);
        last_ready = ready_r;
        last_reset = rst;
        last_data  = bus.o_tx_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] qbyte(input int k);
        if (k < q.size()) return q[k];
        return 8'hxx;
    endfunction

    function automatic logic [7:0] exp_byte(input int mode, input int k);
        logic [31:0] f;
        f = (mode == 1) ? 32'hDEADBEEF : 32'h100 + 32'(k / 4);
        return f[8*(3 - (k % 4)) +: 8];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_until_idle(input int budget, output int done_cnt);
        done_cnt = 0;
        for (int i = 0; i < budget; i++) begin
            if (done) done_cnt++;
            if (!busy) break;
            step();
        end
        check("idle_reached", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_stream(input string tag, input int mode);
        int bad;
        bad = 0;
        for (int k = 0; k < q.size(); k++) if (q[k] !== exp_byte(mode, k)) bad++;
        check({tag, "_count"}, q.size(), 32'd128);
        check({tag, "_bad_bytes"}, bad, 32'd0);
    endtask

    initial begin
        int dc;
        int n;
        rst   = 1'b1;
        start = 1'b0;

        // Reset then idle
        repeat (2) step();
        check("rst_select", {26'd0, bus.o_request_select}, 32'h20);
        check("rst_valid",  {31'd0, bus.o_tx_valid}, 32'd0);
        check("rst_busy",   {31'd0, busy},  32'd0);
        check("rst_done",   {31'd0, done},  32'd0);
        check("rst_error",  {31'd0, error}, 32'd0);
        rst = 1'b0;
        step();

        // Clean dump, ready always high
        q.delete();
        pulse_start();
        check("start_select", {26'd0, bus.o_request_select}, 32'h00);
        check("start_busy",   {31'd0, busy}, 32'd1);
        step();
        check("lat_valid_e1", {31'd0, bus.o_tx_valid}, 32'd0);
        step();
        check("lat_valid_e2", {31'd0, bus.o_tx_valid}, 32'd1);
        check("lat_data_e2",  {24'd0, bus.o_tx_data}, 32'h00);
        run_until_idle(1000, dc);
        check("clean_done_pulses", dc, 32'd1);
        check("clean_error", {31'd0, error}, 32'd0);
        check("clean_idle_select", {26'd0, bus.o_request_select}, 32'h20);
        check("clean_b0", {24'd0, qbyte(0)}, 32'h00);
        check("clean_b1", {24'd0, qbyte(1)}, 32'h00);
        check("clean_b2", {24'd0, qbyte(2)}, 32'h01);
        check("clean_b3", {24'd0, qbyte(3)}, 32'h00);
        check("clean_b4", {24'd0, qbyte(4)}, 32'h00);
        check("clean_b5", {24'd0, qbyte(5)}, 32'h00);
        check("clean_b6", {24'd0, qbyte(6)}, 32'h01);
        check("clean_b7", {24'd0, qbyte(7)}, 32'h01);
        check("clean_b124", {24'd0, qbyte(124)}, 32'h00);
        check("clean_b125", {24'd0, qbyte(125)}, 32'h00);
        check("clean_b126", {24'd0, qbyte(126)}, 32'h01);
        check("clean_b127", {24'd0, qbyte(127)}, 32'h1F);
        check_stream("clean", 0);

        // Backpressure: ready one cycle in three, frame 0xDEADBEEF
        ctrl_mode = 1;
        rdy_mode  = 1;
        stall_err = 0;
        q.delete();
        pulse_start();
        run_until_idle(3000, dc);
        check("bp_done_pulses", dc, 32'd1);
        check("bp_b0", {24'd0, qbyte(0)}, 32'hDE);
        check("bp_b1", {24'd0, qbyte(1)}, 32'hAD);
        check("bp_b2", {24'd0, qbyte(2)}, 32'hBE);
        check("bp_b3", {24'd0, qbyte(3)}, 32'hEF);
        check_stream("bp", 1);
        check("bp_stall_stable", stall_err, 32'd0);
        rdy_mode = 0;

        // Timeout: controller never acknowledges
        ctrl_mode = 2;
        q.delete();
        pulse_start();
        n = 0;
        while (!error && n < 40) begin
            step();
            n++;
        end
        check("tmo_edges", n, 32'd16);
        check("tmo_done", {31'd0, done}, 32'd1);
        check("tmo_select", {26'd0, bus.o_request_select}, 32'h20);
        step();
        check("tmo_busy_after", {31'd0, busy}, 32'd0);
        check("tmo_error_sticky", {31'd0, error}, 32'd1);
        check("tmo_no_bytes", q.size(), 32'd0);

        // Next start clears error; then reset after byte 2 of addr 5
        ctrl_mode = 0;
        pulse_start();
        check("restart_error_clr", {31'd0, error}, 32'd0);
        n = 0;
        while (q.size() < 22 && n < 400) begin
            step();
            n++;
        end
        check("midrst_reach", q.size(), 32'd22);
        rst = 1'b1;
        step();
        check("midrst_valid",  {31'd0, bus.o_tx_valid}, 32'd0);
        check("midrst_select", {26'd0, bus.o_request_select}, 32'h20);
        check("midrst_busy",   {31'd0, busy}, 32'd0);
        check("midrst_done",   {31'd0, done}, 32'd0);
        rst = 1'b0;
        step();
        check("midrst_done_after", {31'd0, done}, 32'd0);
        check("midrst_bytes", q.size(), 32'd22);

        // Restart from addr 0; start pulses during SEND at addr 3 are ignored
        q.delete();
        pulse_start();
        check("rs_select", {26'd0, bus.o_request_select}, 32'h00);
        n = 0;
        while (q.size() < 13 && n < 400) begin
            step();
            n++;
        end
        check("rs_addr3_select", {26'd0, bus.o_request_select}, 32'h03);
        start = 1'b1;
        step();
        step();
        start = 1'b0;
        run_until_idle(1000, dc);
        check("rs_done_pulses", dc, 32'd1);
        check("rs_b0", {24'd0, qbyte(0)}, 32'h00);
        check("rs_b2", {24'd0, qbyte(2)}, 32'h01);
        check("rs_b127", {24'd0, qbyte(127)}, 32'h1F);
        check_stream("rs", 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/debug_regfile_dump_sequencer.md
Name: debug_regfile_dump_sequencer

Overview:
Requesting end of the debug register-file channel. On a start pulse it walks register addresses 0..N_REGS-1 and drives the 6-bit request select (bit5=0 selects the regfile controller, low 5 bits are the register address). It captures each returned 32-bit frame once the controller acknowledges through its registered writing flag, then streams the frame MSB-byte-first to the UART TX through a valid/ready byte handshake. It sits inside the debug unit, between the regfile controller and the TX serializer.

Parameters:
NB_CONTROL_FRAME, 32, frame width from the controller; must be a multiple of NB_BYTE
NB_BYTE, 8, TX byte width
N_REGS, 32, registers dumped, 1..32
NB_TIMEOUT, 4, width of the acknowledge-timeout counter; timeout = 2**NB_TIMEOUT-1 cycles
IDLE_SELECT, 6'b100000, select value driven when not requesting (bit5=1, regfile controller does not match)

Ports:
i_clock  in  1  single clock; all logic on rising edge
i_reset  in  1  synchronous, active-high reset
i_start  in  1  single-cycle dump request; ignored unless in IDLE
i_frame_from_controller  in  NB_CONTROL_FRAME  frame returned for the current address
i_writing  in  1  controller acknowledge (registered request match)
i_tx_ready  in  1  TX can accept a byte
o_request_select  out  6  {match bit, reg addr} to the controller
o_tx_data  out  NB_BYTE  byte to TX
o_tx_valid  out  1  o_tx_data valid
o_busy  out  1  high in any state except IDLE
o_done  out  1  one-cycle pulse at end of dump
o_error  out  1  sticky timeout flag; cleared by reset or next accepted i_start

Behaviour:
- All outputs registered. Reset values: o_request_select=IDLE_SELECT, o_tx_data=0, o_tx_valid=0, o_busy=0, o_done=0, o_error=0, addr=0, byte count=0, state=IDLE.
- Reset asserted mid-dump: next edge returns to reset state. o_tx_valid drops even if a byte is pending, and no done pulse is issued.
- FSM states: IDLE, REQUEST, CAPTURE, SEND, DONE.
- IDLE: select=IDLE_SELECT. When i_start=1: addr<=0, o_error<=0, select<={1'b0,5'd0}, go to REQUEST.
- REQUEST: lasts exactly 1 cycle so that the controller's registered flag and data settle for the new address. Clear the timeout counter, then go to CAPTURE.
- CAPTURE: when i_writing=1, latch i_frame_from_controller into the shift register, set byte count=0, drive o_tx_data=frame[MSB byte], set o_tx_valid=1, and go to SEND.
  - If i_writing=0, increment the timeout counter. On reaching all-ones: o_error<=1, go to DONE, and send no bytes for this register.
  - i_writing already high from the previous address is legal; the REQUEST settle cycle guarantees the data belongs to the current address.
- SEND: a transfer occurs on an edge where o_tx_valid=1 and i_tx_ready=1.
  - While i_tx_ready=0, o_tx_valid and o_tx_data hold stable.
  - On a transfer that is not the last byte: shift left by NB_BYTE, present the next byte, keep valid high (back-to-back transfers allowed).
  - On the last byte (count=NB_CONTROL_FRAME/NB_BYTE-1): o_tx_valid<=0.
    - If addr=N_REGS-1, go to DONE.
    - Otherwise addr<=addr+1, select<={1'b0,addr+1}, go to REQUEST.
- DONE: o_done=1 for exactly one cycle, select<=IDLE_SELECT, then IDLE. o_error persists.
- i_start while busy is ignored, with no restart and no queueing.
- Address never wraps: counts 0..N_REGS-1 only. Total bytes per clean dump = N_REGS*NB_CONTROL_FRAME/NB_BYTE (128 by default).
- Minimum latency: i_start edge -> select=0x00 at the same edge. With i_writing already high, o_tx_valid rises 2 edges later. Per register, minimum is 2 + 4 cycles with i_tx_ready held high.

Decomposition:
- Shared debug package holds:
  - State encodings.
  - IDLE_SELECT.
  - Select field positions: match bit = 5, address = [4:0].
  - BYTES_PER_FRAME = NB_CONTROL_FRAME/NB_BYTE.
- One natural sub-module: debug_frame_byte_serializer, which takes a parallel load of a frame and handles the valid/ready byte shifter and byte counter. It asserts a last-byte pulse to the FSM.

Test Plan:
- Reset then idle: i_reset high 2 cycles -> select=6'h20, valid/busy/done/error=0; i_start pulse -> select=6'h00, busy=1 next edge.
- Clean dump, i_tx_ready=1, model returns frame 0x0000_0100+addr -> 128 bytes, starting 00 00 01 00 00 00 01 01 … ending 00 00 01 1F; one o_done pulse; error=0.
- Backpressure: i_tx_ready toggled 1-of-3 cycles, frame 0xDEADBEEF -> bytes DE AD BE EF in order, data stable while valid high and ready low, no loss or duplication.
- Timeout: i_writing held 0 at addr 0 -> after 15 CAPTURE cycles o_error=1, o_done pulse, zero bytes sent, select=6'h20; the next i_start clears o_error.
- Reset mid-frame after byte 2 of addr 5 -> valid=0, select=6'h20, busy=0 next edge; no done pulse; new start restarts at addr 0.
- i_start pulses during SEND at addr 3 -> ignored; the sequence continues unchanged to addr 31.
